mem_port_arbiter: RTL and testbench

- Shares one single-port data/instruction RAM between two requesters: the fetch stage (IF port) and the memory stage (DM port).
- Accepts at most one access per cycle and drives the RAM command.
- Routes read data back to the owning requester after a fixed RAM read latency.
- Uses fixed DM priority, with a starvation guard that forces an IF grant after a bounded wait.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the fetch (IF) and memory (DM) stages.
// DM wins collisions unless IF has been refused STARVE_MAX cycles in a row.
// Read returns are tracked by a small {valid, owner} shift register so data
// is steered back to the requester that issued the read.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Reject parameter values the return pipeline and counter cannot support
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  logic [3:0]        starve_cnt;
  logic              if_prio;
  logic              if_gnt;
  logic              dm_gnt;
  logic              rd_accept;
  logic [RD_LAT-1:0] ret_vld;
  logic [RD_LAT-1:0] ret_is_if;

  // Arbitration: DM first, IF when it has waited long enough; nothing in reset
  always_comb begin
    if_prio = (starve_cnt == STARVE_LIM);
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    if (rst_ni) begin
      if (if_req_i && (!dm_req_i || if_prio)) begin
        if_gnt = 1'b1;
      end else if (dm_req_i) begin
        dm_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o  = if_gnt;
  assign dm_gnt_o  = dm_gnt;
  assign rd_accept = if_gnt | (dm_gnt & ~dm_we_i);

  // RAM command is steered from whichever port won this cycle
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (if_gnt) begin
      ram_en_o   = 1'b1;
      ram_addr_o = if_addr_i;
    end else if (dm_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = dm_we_i;
      ram_addr_o  = dm_addr_i;
      ram_wdata_o = dm_wdata_i;
    end
  end

  // Count consecutive refused IF cycles, saturating at the priority threshold
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (if_req_i && !if_gnt) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Shift {valid, owner} along with the RAM read latency; reset drops in-flight reads
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ret_vld   <= '0;
      ret_is_if <= '0;
    end else begin
      ret_vld[0]   <= rd_accept;
      ret_is_if[0] <= if_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        ret_vld[i]   <= ret_vld[i-1];
        ret_is_if[i] <= ret_is_if[i-1];
      end
    end
  end

  assign if_rvalid_o = rst_ni & ret_vld[RD_LAT-1] & ret_is_if[RD_LAT-1];
  assign dm_rvalid_o = rst_ni & ret_vld[RD_LAT-1] & ~ret_is_if[RD_LAT-1];
  assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share
// the same stimulus and are compared against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SMAX = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] ram_rdata_i;

  logic          a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_ram_en, a_ram_we;
  logic [DW-1:0] a_if_rdata, a_dm_rdata, a_ram_wdata;
  logic [AW-1:0] a_ram_addr;
  logic          b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_ram_en, b_ram_we;
  logic [DW-1:0] b_if_rdata, b_dm_rdata, b_ram_wdata;
  logic [AW-1:0] b_ram_addr;

  // Free-running clock
  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(SMAX)) dut_lat1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(a_dm_gnt), .dm_rvalid_o(a_dm_rvalid), .dm_rdata_o(a_dm_rdata),
    .ram_en_o(a_ram_en), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
    .ram_wdata_o(a_ram_wdata), .ram_rdata_i(ram_rdata_i)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(SMAX)) dut_lat3 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rvalid), .dm_rdata_o(b_dm_rdata),
    .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(ram_rdata_i)
  );

  typedef struct {
    int due;
    bit is_if;
  } ret_t;

  typedef struct {
    logic rst, ifq, dmq, we;
    logic g_if, g_dm;
    logic v1_if, v1_dm, v3_if, v3_dm;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   starve_m = 0;
  ret_t q1[$];
  ret_t q3[$];
  bit   m_if_gnt, m_dm_gnt;
  logic s_if_gnt, s_dm_gnt, s_ifv1, s_dmv1, s_ifv3, s_dmv3;
  vec_t tab[27];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    else passes++;
  endtask

  // Drive one cycle, compare both instances with the model, advance the model
  task automatic applyStimulus(input logic rst, input logic ifq, input logic dmq, input logic we,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    bit e_if, e_dm, e_en, e_we;
    bit e_ifv1, e_dmv1, e_ifv3, e_dmv3;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    rst_ni = rst; if_req_i = ifq; dm_req_i = dmq; dm_we_i = we;
    if_addr_i = ia; dm_addr_i = da; dm_wdata_i = wd; ram_rdata_i = rd;
    #1;
    e_if   = rst && ifq && (!dmq || starve_m >= SMAX);
    e_dm   = rst && dmq && !e_if;
    e_en   = e_if || e_dm;
    e_we   = e_dm && we;
    e_addr = e_if ? ia : (e_dm ? da : '0);
    e_wd   = e_dm ? wd : '0;
    e_ifv1 = 0; e_dmv1 = 0; e_ifv3 = 0; e_dmv3 = 0;
    if (rst && q1.size() > 0 && q1[0].due == cyc) begin
      e_ifv1 = q1[0].is_if; e_dmv1 = !q1[0].is_if;
    end
    if (rst && q3.size() > 0 && q3[0].due == cyc) begin
      e_ifv3 = q3[0].is_if; e_dmv3 = !q3[0].is_if;
    end
    checkOutput("l1_if_gnt", 64'(a_if_gnt), 64'(e_if));
    checkOutput("l1_dm_gnt", 64'(a_dm_gnt), 64'(e_dm));
    checkOutput("l1_ram_en", 64'(a_ram_en), 64'(e_en));
    checkOutput("l1_ram_we", 64'(a_ram_we), 64'(e_we));
    checkOutput("l1_ram_addr", a_ram_addr, e_addr);
    checkOutput("l1_ram_wdata", a_ram_wdata, e_wd);
    checkOutput("l1_if_rvalid", 64'(a_if_rvalid), 64'(e_ifv1));
    checkOutput("l1_dm_rvalid", 64'(a_dm_rvalid), 64'(e_dmv1));
    checkOutput("l1_if_rdata", a_if_rdata, e_ifv1 ? rd : '0);
    checkOutput("l1_dm_rdata", a_dm_rdata, e_dmv1 ? rd : '0);
    checkOutput("l3_if_gnt", 64'(b_if_gnt), 64'(e_if));
    checkOutput("l3_dm_gnt", 64'(b_dm_gnt), 64'(e_dm));
    checkOutput("l3_ram_we", 64'(b_ram_we), 64'(e_we));
    checkOutput("l3_ram_addr", b_ram_addr, e_addr);
    checkOutput("l3_if_rvalid", 64'(b_if_rvalid), 64'(e_ifv3));
    checkOutput("l3_dm_rvalid", 64'(b_dm_rvalid), 64'(e_dmv3));
    checkOutput("l3_if_rdata", b_if_rdata, e_ifv3 ? rd : '0);
    checkOutput("l3_dm_rdata", b_dm_rdata, e_dmv3 ? rd : '0);
    s_if_gnt = a_if_gnt; s_dm_gnt = a_dm_gnt;
    s_ifv1 = a_if_rvalid; s_dmv1 = a_dm_rvalid;
    s_ifv3 = b_if_rvalid; s_dmv3 = b_dm_rvalid;
    m_if_gnt = e_if; m_dm_gnt = e_dm;
    if (!rst) begin
      q1.delete(); q3.delete();
      starve_m = 0;
    end else begin
      if (e_ifv1 || e_dmv1) void'(q1.pop_front());
      if (e_ifv3 || e_dmv3) void'(q3.pop_front());
      if (e_if || (e_dm && !we)) begin
        q1.push_back('{due: cyc + 1, is_if: e_if});
        q3.push_back('{due: cyc + 3, is_if: e_if});
      end
      if (ifq && !e_if) starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
      else starve_m = 0;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  // Main sequence: directed table, reset-in-flight case, then random traffic
  initial begin
    bit p_if, p_dm, p_we, r_rst;
    logic [AW-1:0] p_ia, p_da;
    logic [DW-1:0] p_wd;
    tab[0]  = '{0,1,1,0, 0,0, 0,0,0,0};
    tab[1]  = '{0,1,1,0, 0,0, 0,0,0,0};
    tab[2]  = '{0,1,1,0, 0,0, 0,0,0,0};
    tab[3]  = '{1,1,1,0, 0,1, 0,0,0,0};
    tab[4]  = '{1,1,1,0, 0,1, 0,1,0,0};
    tab[5]  = '{1,1,1,0, 0,1, 0,1,0,0};
    tab[6]  = '{1,1,1,0, 1,0, 0,1,0,1};
    tab[7]  = '{1,1,1,0, 0,1, 1,0,0,1};
    tab[8]  = '{1,1,1,1, 0,1, 0,1,0,1};
    tab[9]  = '{1,1,1,1, 0,1, 0,0,1,0};
    tab[10] = '{1,1,0,0, 1,0, 0,0,0,1};
    tab[11] = '{1,0,0,0, 0,0, 1,0,0,0};
    tab[12] = '{1,0,0,0, 0,0, 0,0,0,0};
    tab[13] = '{1,0,0,0, 0,0, 0,0,1,0};
    tab[14] = '{1,1,0,0, 1,0, 0,0,0,0};
    tab[15] = '{0,1,1,0, 0,0, 0,0,0,0};
    tab[16] = '{1,0,0,0, 0,0, 0,0,0,0};
    tab[17] = '{1,0,0,0, 0,0, 0,0,0,0};
    tab[18] = '{1,0,0,0, 0,0, 0,0,0,0};
    tab[19] = '{1,1,1,0, 0,1, 0,0,0,0};
    tab[20] = '{1,1,1,0, 0,1, 0,1,0,0};
    tab[21] = '{1,1,0,0, 1,0, 0,1,0,0};
    tab[22] = '{1,0,1,0, 0,1, 1,0,0,1};
    tab[23] = '{1,0,0,0, 0,0, 0,1,0,1};
    tab[24] = '{1,0,0,0, 0,0, 0,0,1,0};
    tab[25] = '{1,0,0,0, 0,0, 0,0,0,1};
    tab[26] = '{1,0,0,0, 0,0, 0,0,0,0};

    rst_ni = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; ram_rdata_i = '0;
    @(negedge clk_i);

    $display("[TB] directed table");
    for (int i = 0; i < 27; i++) begin
      applyStimulus(tab[i].rst, tab[i].ifq, tab[i].dmq, tab[i].we,
                    64'h100 + 64'(i), 64'h40 + 64'(i), 64'h55 + 64'(i),
                    64'hDEAD_BEEF + 64'(i));
      checkOutput("tab_if_gnt", 64'(s_if_gnt), 64'(tab[i].g_if));
      checkOutput("tab_dm_gnt", 64'(s_dm_gnt), 64'(tab[i].g_dm));
      checkOutput("tab_l1_if_rvalid", 64'(s_ifv1), 64'(tab[i].v1_if));
      checkOutput("tab_l1_dm_rvalid", 64'(s_dmv1), 64'(tab[i].v1_dm));
      checkOutput("tab_l3_if_rvalid", 64'(s_ifv3), 64'(tab[i].v3_if));
      checkOutput("tab_l3_dm_rvalid", 64'(s_dmv3), 64'(tab[i].v3_dm));
    end

    $display("[TB] reset during in-flight IF read");
    applyStimulus(1, 1, 0, 0, 64'h100, 64'h0, 64'h0, 64'h0);
    checkOutput("mid_rst_if_gnt", 64'(s_if_gnt), 64'd1);
    applyStimulus(0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF);
    for (int i = 2; i <= 6; i++) begin
      applyStimulus(1, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF);
      checkOutput("mid_rst_l3_if_rvalid", 64'(s_ifv3), 64'd0);
      checkOutput("mid_rst_l1_if_rvalid", 64'(s_ifv1), 64'd0);
    end

    $display("[TB] random traffic");
    p_if = 0; p_dm = 0; p_we = 0; p_ia = '0; p_da = '0; p_wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!p_if) begin
        p_if = ($urandom_range(0, 2) != 0);
        p_ia = {$urandom, $urandom};
      end
      if (!p_dm) begin
        p_dm = ($urandom_range(0, 2) != 0);
        p_we = $urandom_range(0, 1) == 1;
        p_da = {$urandom, $urandom};
        p_wd = {$urandom, $urandom};
      end
      r_rst = ($urandom_range(0, 49) != 0);
      applyStimulus(r_rst, p_if, p_dm, p_we, p_ia, p_da, p_wd, {$urandom, $urandom});
      if (m_if_gnt) p_if = 0;
      if (m_dm_gnt) p_dm = 0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
